// File: rtl/sipo_frame_receiver_pkg.sv
// Shared types and sizing helpers for the serial-in, parallel-out frame receiver.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-count register width: it must hold every value from 0 up to WIDTH+PARITY.
  function automatic int cnt_w(input int width, input int parity);
    return $clog2(width + parity + 1);
  endfunction

endpackage

// File: rtl/sipo_frame_receiver_if.sv
// Serial input and parallel valid/ready output bundle of the frame receiver.
interface sipo_frame_receiver_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic             lsb_first;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  // Bit-stream source and word consumer side.
  modport master (
    output sin, sin_valid, sof, lsb_first, dout_ready,
    input  dout, dout_valid, busy, frame_err, overrun, parity_err
  );

  // Receiver side.
  modport slave (
    input  sin, sin_valid, sof, lsb_first, dout_ready,
    output dout, dout_valid, busy, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/sipo_frame_receiver_shifter.sv
// Bidirectional WIDTH-bit shift register with a latched direction and a bit counter.
// Bits beyond WIDTH (the parity bit) advance the counter but leave the data alone.
module sipo_shifter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w(4, 0)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,       // start a frame with bit_in as its first bit
  input  logic             shift,      // append bit_in to the frame in progress
  input  logic             done,       // this shift completes the frame
  input  logic             bit_in,
  input  logic             load_lsb,   // bit order for the frame being started
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_shift, // data with bit_in already shifted in
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsb_q, lsb_d;

  // Next-state of register, direction and count for load / shift / hold.
  always_comb begin
    data_shift = lsb_q ? {bit_in, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], bit_in};
    data_d     = data_q;
    cnt_d      = cnt_q;
    lsb_d      = lsb_q;
    if (load) begin
      lsb_d  = load_lsb;
      data_d = '0;
      if (load_lsb) data_d[WIDTH-1] = bit_in;
      else          data_d[0]       = bit_in;
      cnt_d  = CNT_W'(1);
    end else if (shift) begin
      if (cnt_q < CNT_W'(WIDTH)) data_d = data_shift;
      cnt_d = done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
      lsb_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      lsb_q  <= lsb_d;
    end
  end

  assign data = data_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial-in, parallel-out frame receiver: frames a strobed bit stream into WIDTH-bit
// words, checks optional even parity and presents words in a one-entry output register.
module sipo_frame_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int PARITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  sipo_frame_receiver_if.slave  bus
);

  localparam int               CNT_W = cnt_w(WIDTH, PARITY);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH + PARITY - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;

  logic             start, shift, done;
  logic [WIDTH-1:0] sh_data, sh_data_shift, word;
  logic [CNT_W-1:0] sh_cnt;

  sipo_shifter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .shift      (shift),
    .done       (done),
    .bit_in     (bus.sin),
    .load_lsb   (bus.lsb_first),
    .data       (sh_data),
    .data_shift (sh_data_shift),
    .cnt        (sh_cnt)
  );

  // Framing FSM, parity check and one-entry output register next-state.
  always_comb begin
    // A sof always starts a fresh frame, even on what would have been the completing bit.
    start = bus.sin_valid && bus.sof;
    shift = (state_q == SHIFT) && bus.sin_valid && !bus.sof;
    done  = shift && (sh_cnt == LAST);
    // With parity the data register is already full when the parity bit arrives.
    word  = (PARITY != 0) ? sh_data : sh_data_shift;

    state_d = state_q;
    if (start)     state_d = SHIFT;
    else if (done) state_d = IDLE;
    busy_d       = (state_d == SHIFT);
    frame_err_d  = start && (state_q == SHIFT);

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !bus.dout_ready;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
    if (done) begin
      if (!dout_valid_q || bus.dout_ready) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
        parity_err_d = (PARITY != 0) ? ((^sh_data) ^ bus.sin) : 1'b0;
      end else begin
        overrun_d    = 1'b1;
      end
    end
  end

  // Registered state and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.parity_err = parity_err_q;

endmodule
